// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: valid/ready request channel plus a valid-only response channel.
// The master side is the fetch unit and the slave side is instruction memory.
interface pc_fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher.
// It holds the fetched instruction until the control unit writes a new PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             pc_next,
  input  logic                    pc_write,
  output logic [31:0]             pc,
  output logic [31:0]             pc_plus4,
  pc_fetch_unit_if.master         imem,
  output logic                    ir_valid,
  output logic [31:0]             ir,
  output logic [31:0]             ir_pc,
  output logic                    drop_pending
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic        req_valid_q;
  logic [31:0] req_pc;

  assign pc_plus4       = pc + 32'd4;
  assign imem.addr      = pc;
  assign imem.req_valid = req_valid_q;

  // A PC write while a response is owed marks that response stale, so it is
  // consumed and thrown away before the next request goes out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_REQ;
      req_valid_q  <= 1'b1;
      pc           <= RESET_VECTOR;
      req_pc       <= 32'd0;
      ir_valid     <= 1'b0;
      ir           <= 32'd0;
      ir_pc        <= 32'd0;
      drop_pending <= 1'b0;
    end else begin
      if (pc_write) begin
        pc <= pc_next & ~32'd3;
      end
      case (state)
        S_REQ: begin
          if (imem.req_ready) begin
            state        <= S_WAIT;
            req_valid_q  <= 1'b0;
            req_pc       <= pc;
            drop_pending <= pc_write;
          end
        end
        S_WAIT: begin
          if (imem.rsp_valid) begin
            if (drop_pending || pc_write) begin
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state    <= S_HOLD;
              ir       <= imem.rsp_data;
              ir_pc    <= req_pc;
              ir_valid <= 1'b1;
            end
            drop_pending <= 1'b0;
          end else if (pc_write) begin
            drop_pending <= 1'b1;
          end
        end
        S_HOLD: begin
          if (pc_write) begin
            state       <= S_REQ;
            req_valid_q <= 1'b1;
            ir_valid    <= 1'b0;
          end
        end
        default: begin
          state       <= S_REQ;
          req_valid_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic, compared each cycle
// against a transaction-level model of PC, owed response and held instruction.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        pc_write;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        drop_pending;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_next      (pc_next),
    .pc_write     (pc_write),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem         (bus.master),
    .ir_valid     (ir_valid),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .drop_pending (drop_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the PC, whether a response is owed (and for which address), whether that
  // response has been made stale by a PC write, and the held instruction.
  logic [31:0] m_pc;
  logic        m_owed;
  logic [31:0] m_owed_addr;
  logic        m_stale;
  logic        m_ir_valid;
  logic [31:0] m_ir;
  logic [31:0] m_ir_pc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic pw, input logic [31:0] pn,
                           input logic rdy, input logic rv, input logic [31:0] rd);
    logic owed_before;
    logic holding_before;
    logic requesting;
    if (!r) begin
      m_pc       = RV;
      m_owed     = 1'b0;
      m_stale    = 1'b0;
      m_ir_valid = 1'b0;
      m_ir       = 32'd0;
      m_ir_pc    = 32'd0;
    end else begin
      owed_before    = m_owed;
      holding_before = m_ir_valid;
      requesting     = !owed_before && !holding_before;
      if (rv && !owed_before)
        $display("[TB] protocol note: response driven with nothing owed (t=%0t)", $time);
      if (owed_before && rv) begin
        if (!m_stale && !pw) begin
          m_ir_valid = 1'b1;
          m_ir       = rd;
          m_ir_pc    = m_owed_addr;
        end
        m_owed  = 1'b0;
        m_stale = 1'b0;
      end else if (owed_before && pw) begin
        m_stale = 1'b1;
      end
      if (holding_before && pw)
        m_ir_valid = 1'b0;
      if (requesting && rdy) begin
        m_owed      = 1'b1;
        m_owed_addr = m_pc;
        m_stale     = pw;
      end
      if (pw)
        m_pc = {pn[31:2], 2'b00};
    end
  endtask

  task automatic compareAll();
    checkOutput("pc",           pc,                   m_pc);
    checkOutput("pc_plus4",     pc_plus4,             m_pc + 32'd4);
    checkOutput("req_valid",    {31'd0, bus.req_valid}, {31'd0, !m_owed && !m_ir_valid});
    checkOutput("imem_addr",    bus.addr,             m_pc);
    checkOutput("ir_valid",     {31'd0, ir_valid},    {31'd0, m_ir_valid});
    checkOutput("ir",           ir,                   m_ir);
    checkOutput("ir_pc",        ir_pc,                m_ir_pc);
    checkOutput("drop_pending", {31'd0, drop_pending}, {31'd0, m_stale});
  endtask

  task automatic applyStimulus(input logic r, input logic pw, input logic [31:0] pn,
                               input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst_n         = r;
    pc_write      = pw;
    pc_next       = pn;
    bus.req_ready = rdy;
    bus.rsp_valid = rv;
    bus.rsp_data  = rd;
    @(posedge clk);
    modelStep(r, pw, pn, rdy, rv, rd);
    #1;
    compareAll();
  endtask

  initial begin
    logic        r;
    logic        pw;
    logic [31:0] pn;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;

    rst_n         = 1'b0;
    pc_write      = 1'b0;
    pc_next       = 32'd0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 32'd0;
    m_pc = RV; m_owed = 1'b0; m_owed_addr = 32'd0; m_stale = 1'b0;
    m_ir_valid = 1'b0; m_ir = 32'd0; m_ir_pc = 32'd0;

    // Reset, then a zero-wait fetch of 0x13 from the reset vector
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0013);
    checkOutput("first_ir", ir, 32'h0000_0013);

    // Retire and fetch 0x104
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0001);
    checkOutput("ir_pc_104", ir_pc, 32'h104);

    // Stalled request retargets from 0x104 to 0x200 before acceptance
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBBBB_0002);
    checkOutput("ir_pc_200", ir_pc, 32'h200);

    // Fetch 0x300 made stale by a write of 0x400 while waiting
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'd0);
    checkOutput("drop_set", {31'd0, drop_pending}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hCCCC_0003);
    checkOutput("drop_addr", bus.addr, 32'h400);

    // Wraparound of PC+4 and clearing of the low PC bits
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
    checkOutput("plus4_wrap", pc_plus4, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
    checkOutput("pc_lowbits", pc, 32'h10);

    // Reset while waiting, with the response arriving in the same cycle
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("post_reset_req", {31'd0, bus.req_valid}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(63) != 0);
      pw  = ($urandom_range(4) == 0);
      pn  = $urandom;
      rdy = $urandom_range(1);
      rv  = m_owed && ($urandom_range(2) == 0);
      rd  = $urandom;
      applyStimulus(r, pw, pn, rdy, rv, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural program counter and is the consumer of the next-PC select path.
- Registers the selected next PC and issues one instruction fetch at a time to instruction memory over a valid/ready request / valid response interface.
- Holds the returned instruction with its PC for the control unit until that instruction retires.
- Also drives PC+4 back to the next-PC select path as its sequential input.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  reset; synchronous, active-low.
- PC_NEXT  input  32  selected next PC from the next-PC select path.
- PC_WRITE  input  1  control unit: load PC_NEXT into PC, this cycle.
- PC  output  32  current PC register.
- PC_PLUS4  output  32  PC + 4, combinational.
- IMEM_REQ_VALID  output  1  fetch request valid.
- IMEM_REQ_READY  input  1  memory accepts request.
- IMEM_ADDR  output  32  fetch address, equal to PC.
- IMEM_RSP_VALID  input  1  read data valid, one cycle per accepted request.
- IMEM_RSP_DATA  input  32  instruction word.
- IR_VALID  output  1  IR/IR_PC hold a valid fetched instruction.
- IR  output  32  held instruction.
- IR_PC  output  32  PC the held instruction was fetched from.
- DROP_PENDING  output  1  in-flight response will be discarded (debug/visibility).

Behaviour:
- Reset (RST_N=0 at edge), overriding everything including mid-request:
  - PC=RESET_VECTOR, state=S_REQ.
  - IR_VALID=0, IR=0, IR_PC=0, DROP_PENDING=0.
  - IMEM_REQ_VALID is 1 from the first cycle after reset release.
- Arithmetic:
  - PC_PLUS4 = PC+4 modulo 2^32; 32'hFFFF_FFFC+4 = 0.
  - PC_NEXT[1:0] is ignored; PC loads {PC_NEXT[31:2],2'b00}.
- At most one outstanding request; a new request is never issued while a response is owed.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - IMEM_REQ_VALID=1, IMEM_ADDR=PC.
  - REQ_READY=1 -> S_WAIT.
  - An unaccepted request may change address or be withdrawn; the memory side treats only the accepting cycle as binding.
- S_WAIT:
  - IMEM_REQ_VALID=0.
  - On RSP_VALID with DROP_PENDING=0: IR<=RSP_DATA, IR_PC<=address sampled at acceptance, IR_VALID<=1 -> S_HOLD.
  - On RSP_VALID with DROP_PENDING=1: data discarded, DROP_PENDING<=0 -> S_REQ.
- S_HOLD:
  - IR_VALID=1; IR and IR_PC stable.
  - Stays until PC_WRITE, then IR_VALID<=0 -> S_REQ.
- PC_WRITE in any state loads PC next edge. Effects by state:
  - S_REQ, REQ_READY=0: request simply retries next cycle with the new PC.
  - S_REQ, REQ_READY=1 same cycle: old-PC request is in flight -> S_WAIT with DROP_PENDING<=1.
  - S_WAIT, no RSP_VALID: DROP_PENDING<=1.
  - S_WAIT, RSP_VALID same cycle: response discarded, IR_VALID stays 0 -> S_REQ.
- Latency: PC_WRITE at cycle t -> request for the new PC at t+1 -> IR_VALID at the earliest t+2 with a zero-wait memory (ready at t+1, response at t+2 edge).
- Protocol assumptions:
  - RSP_VALID outside S_WAIT is illegal; the bench flags it, and RTL ignores it.
  - PC_WRITE and RSP_VALID are never X after reset.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_0100, zero-wait memory returning 32'h0000_0013 -> REQ_VALID with ADDR=0x100 at cycle 1 after reset release; IR=0x13, IR_PC=0x100, IR_VALID=1 at cycle 2; PC_PLUS4=0x104.
- In S_HOLD assert PC_WRITE with PC_NEXT=0x104 -> IR_VALID drops next cycle; request ADDR=0x104 issued; IR_PC=0x104 after response.
- Memory holds REQ_READY=0 for 3 cycles, PC_WRITE with PC_NEXT=0x200 on the 2nd cycle -> ADDR changes 0x104 -> 0x200; only 0x200 is accepted; IR_PC=0x200.
- Request 0x300 accepted, response delayed 4 cycles, PC_WRITE with PC_NEXT=0x400 in the 2nd wait cycle -> DROP_PENDING=1; the 0x300 response is discarded with IR_VALID=0; next request ADDR=0x400.
- PC=32'hFFFF_FFFC, PC_NEXT=32'h0000_0013 on PC_WRITE -> PC_PLUS4=0 before the write; PC=0x10 after (low bits cleared).
- RST_N low during S_WAIT with a response arriving the same cycle -> response ignored; PC=RESET_VECTOR, IR_VALID=0, DROP_PENDING=0; fresh request issued after release.
